// File: rtl/distributor_logic_parametrised_pkg.sv
// Shared definitions for the one-hot stream distributor: FSM state encoding and error counter width.
package distributor_logic_parametrised_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/distributor_logic_parametrised_if.sv
// Producer/consumer bundle for the distributor; err_count exists only when DIST_ERR_COUNT_EN is defined.
interface distributor_logic_parametrised_if #(
  parameter int data_size = 2,
  parameter int out_val   = 4
);

  logic [data_size-1:0]         in_data;
  logic [out_val-1:0]           in_sel;
  logic                         in_valid;
  logic                         in_ready;
  logic [data_size*out_val-1:0] out_data;
  logic [out_val-1:0]           out_valid;
  logic [out_val-1:0]           out_ready;
  logic                         sel_err;
`ifdef DIST_ERR_COUNT_EN
  logic [distributor_logic_parametrised_pkg::ERR_CNT_W-1:0] err_count;
`endif

  // The environment side: drives the input word and the lane readies.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
`ifdef DIST_ERR_COUNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
`ifdef DIST_ERR_COUNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/distributor_logic_parametrised_onehot_check.sv
// Combinational legality check for the destination select: exactly one bit set.
module onehot_check #(
  parameter int out_val = 4
) (
  input  logic [out_val-1:0] in_sel,
  output logic               is_onehot
);

  assign is_onehot = ($countones(in_sel) == 1);

endmodule

// File: rtl/distributor_logic_parametrised.sv
// One-hot stream distributor: buffers one word and presents it on the lane named by its one-hot tag.
// Optional feature macro: DIST_ERR_COUNT_EN adds a saturating count of dropped selects.
module distributor_logic_parametrised
  import distributor_logic_parametrised_pkg::*;
#(
  parameter int data_size = 2,
  parameter int out_val   = 4
) (
  input logic                           clk,
  input logic                           rst_n,
  distributor_logic_parametrised_if.slave bus
);

  state_t               state;
  logic [data_size-1:0] buf_q;
  logic [out_val-1:0]   dest_q;
  logic                 sel_err_q;
  logic                 is_onehot;
  logic                 accept;
  logic                 drain;
  logic [out_val-1:0]   lane_valid;

  onehot_check #(.out_val(out_val)) u_onehot_check (
    .in_sel    (bus.in_sel),
    .is_onehot (is_onehot)
  );

  // Only the destination lane's ready matters; other lanes cannot unblock the head word.
  assign drain       = (state == ST_FULL) && |(bus.out_ready & dest_q);
  assign bus.in_ready = (state == ST_EMPTY) || drain;
  assign accept      = bus.in_valid && bus.in_ready;

  assign lane_valid    = (state == ST_FULL) ? dest_q : '0;
  assign bus.out_valid = lane_valid;
  assign bus.sel_err   = sel_err_q;

  for (genvar i = 0; i < out_val; i++) begin : g_lane
    assign bus.out_data[i*data_size +: data_size] = buf_q & {data_size{lane_valid[i]}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      buf_q     <= '0;
      dest_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept && !is_onehot;
      if (accept && is_onehot) begin
        state  <= ST_FULL;
        buf_q  <= bus.in_data;
        dest_q <= bus.in_sel;
      end else if (drain) begin
        state <= ST_EMPTY;
      end
    end
  end

`ifdef DIST_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (accept && !is_onehot && (err_q != '1)) begin
      err_q <= err_q + ERR_CNT_W'(1);
    end
  end

  assign bus.err_count = err_q;
`endif

endmodule
